// File: rtl/ahb_checksum_master.sv
// AHB-Lite read master that streams a block of words and folds them into a
// rotate-and-add 32-bit checksum for boot-time integrity checks.
module ahb_checksum_master #(
    parameter int CNT_WIDTH = 16,
    parameter int CSUM_ROT  = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start,
    input  logic [31:0]          base_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          checksum,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [31:0]          HWDATA,
    input  logic                 HREADY,
    input  logic [31:0]          HRDATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t               state_q;
    logic [31:0]          addr_q;
    logic [CNT_WIDTH-1:0] remain_q;
    logic [31:0]          acc_q;
    logic [31:0]          csum_q;
    logic                 dphase_q;
    logic [31:0]          acc_d;
    logic                 base_lsbs_unused;

    assign base_lsbs_unused = ^base_addr[1:0];

    always_comb begin
        acc_d = ((acc_q << CSUM_ROT) | (acc_q >> (32 - CSUM_ROT))) + HRDATA;
    end

    // One HREADY completes both the current address phase and the previous data phase.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            acc_q    <= '0;
            csum_q   <= '0;
            dphase_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= {base_addr[31:2], 2'b00};
                        remain_q <= word_count;
                        acc_q    <= '0;
                        dphase_q <= 1'b0;
                        state_q  <= (word_count == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (HREADY) begin
                        if (dphase_q) begin
                            acc_q <= acc_d;
                        end
                        dphase_q <= 1'b1;
                        addr_q   <= addr_q + 32'd4;
                        remain_q <= remain_q - CNT_WIDTH'(1);
                        if (remain_q == CNT_WIDTH'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (HREADY) begin
                        acc_q    <= acc_d;
                        dphase_q <= 1'b0;
                        state_q  <= S_FIN;
                    end
                end
                S_FIN: begin
                    csum_q  <= acc_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // During FIN the fresh accumulator is presented; afterwards the held copy.
    assign done     = (state_q == S_FIN);
    assign busy     = (state_q != S_IDLE);
    assign checksum = done ? acc_q : csum_q;
    assign HADDR    = addr_q;
    assign HTRANS   = (state_q == S_RUN) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE   = 1'b0;
    assign HSIZE    = 3'b010;
    assign HWDATA   = 32'd0;

endmodule

// File: tb/tb_ahb_checksum_master.sv
// Directed bench for ahb_checksum_master: a small AHB slave model with a
// scripted HREADY stall pattern and a table of transfers with hand-computed results.
module tb_ahb_checksum_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] mem [16];
    logic [31:0] dAddr;
    logic        dValid;

    typedef struct {
        logic [31:0] base;
        int          count;
        int          stallAt;
        int          stallLen;
        logic [31:0] expCsum;
        int          expDone;
    } vec_t;

    vec_t vecs [6];

    ahb_checksum_master #(.CNT_WIDTH(16), .CSUM_ROT(1)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRDATA     (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // Slave model: remembers the accepted address phase and returns its word in the data phase.
    always @(posedge HCLK) begin
        if (!HRESETn) begin
            dValid <= 1'b0;
            dAddr  <= 32'd0;
        end else if (HREADY) begin
            dValid <= (HTRANS == 2'b10);
            dAddr  <= HADDR;
        end
    end

    assign HRDATA = dValid ? mem[dAddr[5:2]] : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] expAddr;
        int          accepted;
        @(negedge HCLK);
        start      = 1'b1;
        base_addr  = v.base;
        word_count = v.count[15:0];
        HREADY     = 1'b1;
        expAddr    = {v.base[31:2], 2'b00};
        accepted   = 0;
        for (int cyc = 1; cyc <= v.expDone + 1; cyc++) begin
            @(negedge HCLK);
            start = 1'b0;
            checkOutput("htrans", {30'd0, HTRANS}, (accepted < v.count) ? 32'd2 : 32'd0);
            if (HTRANS == 2'b10) begin
                checkOutput("haddr", HADDR, expAddr);
            end
            checkOutput("busy", {31'd0, busy}, {31'd0, cyc <= v.expDone});
            checkOutput("done", {31'd0, done}, {31'd0, cyc == v.expDone});
            if (cyc >= v.expDone) begin
                checkOutput("checksum", checksum, v.expCsum);
            end
            HREADY = !(cyc >= v.stallAt && cyc < v.stallAt + v.stallLen);
            if (HTRANS == 2'b10 && HREADY) begin
                accepted++;
                expAddr = expAddr + 32'd4;
            end
        end
        HREADY = 1'b1;
        checkOutput("accepted", accepted, v.count);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'd0;
        end
        mem[0]  = 32'd1;
        mem[1]  = 32'd2;
        mem[2]  = 32'd3;
        mem[3]  = 32'd4;
        mem[4]  = 32'h8000_0000;
        mem[5]  = 32'd1;
        mem[15] = 32'd5;

        vecs[0] = '{base: 32'h0000_0000, count: 4, stallAt: 0, stallLen: 0, expCsum: 32'h1A, expDone: 6};
        vecs[1] = '{base: 32'h0000_0000, count: 4, stallAt: 2, stallLen: 2, expCsum: 32'h1A, expDone: 8};
        vecs[2] = '{base: 32'h0000_0040, count: 0, stallAt: 0, stallLen: 0, expCsum: 32'h0,  expDone: 1};
        vecs[3] = '{base: 32'hFFFF_FFFE, count: 2, stallAt: 0, stallLen: 0, expCsum: 32'hB,  expDone: 4};
        vecs[4] = '{base: 32'h0000_0010, count: 2, stallAt: 0, stallLen: 0, expCsum: 32'h2,  expDone: 4};
        vecs[5] = '{base: 32'h0000_0003, count: 1, stallAt: 0, stallLen: 0, expCsum: 32'h1,  expDone: 3};

        HRESETn    = 1'b0;
        start      = 1'b0;
        base_addr  = 32'd0;
        word_count = 16'd0;
        HREADY     = 1'b1;
        repeat (3) @(negedge HCLK);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_checksum", checksum, 32'd0);
        checkOutput("rst_htrans", {30'd0, HTRANS}, 32'd0);
        checkOutput("rst_haddr", HADDR, 32'd0);
        checkOutput("hwrite", {31'd0, HWRITE}, 32'd0);
        checkOutput("hsize", {29'd0, HSIZE}, 32'd2);
        checkOutput("hwdata", HWDATA, 32'd0);
        HRESETn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d base=0x%08h count=%0d", i, vecs[i].base, vecs[i].count);
            applyStimulus(vecs[i]);
        end

        // Second start mid-run must be ignored, then reset abandons the transfer.
        @(negedge HCLK);
        start      = 1'b1;
        base_addr  = 32'h0;
        word_count = 16'd4;
        @(negedge HCLK);
        checkOutput("mid_haddr1", HADDR, 32'h0);
        start      = 1'b1;
        base_addr  = 32'h100;
        word_count = 16'd0;
        @(negedge HCLK);
        start = 1'b0;
        checkOutput("mid_haddr2", HADDR, 32'h4);
        checkOutput("mid_htrans2", {30'd0, HTRANS}, 32'd2);
        @(negedge HCLK);
        checkOutput("mid_haddr3", HADDR, 32'h8);
        checkOutput("mid_busy", {31'd0, busy}, 32'd1);
        checkOutput("mid_done", {31'd0, done}, 32'd0);
        HRESETn = 1'b0;
        @(negedge HCLK);
        checkOutput("mrst_htrans", {30'd0, HTRANS}, 32'd0);
        checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mrst_done", {31'd0, done}, 32'd0);
        checkOutput("mrst_checksum", checksum, 32'd0);
        checkOutput("mrst_haddr", HADDR, 32'd0);
        HRESETn = 1'b1;

        applyStimulus(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
